fifo_wrt_arbiter: RTL and testbench
===================================

FIFO_WRT_ARBITER -- requirements
Module: fifo_wrt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port; legal values 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: write-data width, equal to the FIFO memory data width.
REQ-003 Parameter ID_W, default 2: grant-ID width, equal to clog2(NUM_REQ).
REQ-004 wrt_clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 wrt_rst_n  input  1: reset, synchronous and active-low.
REQ-006 req  input  NUM_REQ: per-requester write request, held high until granted.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH: requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH], stable while req[i] is high.
REQ-008 req_lock  input  NUM_REQ: per-requester burst-lock request; used only when WRT_ARB_LOCK_EN is defined.
REQ-009 wrt_full  input  1: FIFO full flag from the write-side pointer logic.
REQ-010 gnt  output  NUM_REQ: one-hot grant; req[i] & gnt[i] at a rising edge is one accepted word.
REQ-011 wrt_ena  output  1: FIFO memory write enable, equal to |gnt.
REQ-012 wrt_data  output  DATA_WIDTH: data of the granted requester; all zeros when gnt is all zeros.
REQ-013 gnt_id  output  ID_W: binary index of the granted requester; 0 when no grant.

Function
REQ-014 gnt, wrt_ena, wrt_data and gnt_id shall be combinational from req, wrt_full and registered state (zero-latency grant).
REQ-015 When wrt_full=1, gnt shall be all zeros, so no word is lost or duplicated at the memory.
REQ-016 Arbitration shall be round-robin: search starts at prio_ptr and increments modulo NUM_REQ; the first set req bit wins.
REQ-017 On each accepted transfer by requester k, prio_ptr shall load (k+1) mod NUM_REQ; prio_ptr shall otherwise hold.
REQ-018 The FSM shall have states IDLE (no requests), ARB (requests pending, arbitrating) and LOCK (port owned by lock_owner).
REQ-019 IDLE->ARB when |req=1 at an edge; ARB->IDLE when req=0; ARB and IDLE shall both grant combinationally in the same cycle a request is seen.
REQ-020 At most one gnt bit shall be high in any cycle, and gnt[i] shall be high only if req[i] is high.
REQ-021 When one requester holds req continuously and others are idle, it shall be granted every non-full cycle (full throughput).
REQ-022 When wrt_full deasserts, arbitration shall resume from the unchanged prio_ptr.

Reset
REQ-023 While wrt_rst_n=0 at an edge: state=IDLE, prio_ptr=0, lock_owner=0.
REQ-024 While wrt_rst_n is low, gnt=0, wrt_ena=0, wrt_data=0 and gnt_id=0, regardless of req.
REQ-025 Reset asserted mid-lock shall abandon the lock; the first post-reset grant shall follow round-robin from index 0.

Configuration
REQ-026 Macro WRT_ARB_LOCK_EN defined: an accepted transfer by k with req_lock[k]=1 moves the FSM to LOCK with lock_owner=k.
REQ-027 In LOCK, only lock_owner may be granted, and the FSM shall stay in LOCK through wrt_full stalls.
REQ-028 LOCK shall exit to ARB on an accepted owner transfer with req_lock=0, or on any cycle where req[lock_owner]=0.
REQ-029 Macro undefined: req_lock shall be ignored, LOCK shall be unreachable and its logic not synthesized.

Verification
REQ-030 Reset with req=4'b1111 held low -> gnt=0, wrt_ena=0; after release, grants are 0,1,2,3,0 on consecutive cycles with wrt_data matching.
REQ-031 req=4'b0100 only, wrt_full=0 for 5 cycles -> gnt=4'b0100 every cycle, 5 writes, gnt_id=2.
REQ-032 req=4'b1010, wrt_full=1 for 3 cycles, then 0 -> no gnt while full; then gnt 4'b0010, 4'b1000 alternating.
REQ-033 WRT_ARB_LOCK_EN defined, req0 with lock=1 for 3 words, req1 pending -> 3 consecutive grants to 0; the grant after lock drops goes to 1.
REQ-034 WRT_ARB_LOCK_EN defined, reset pulsed mid-lock -> outputs zero during reset; afterwards the FSM is not in LOCK and arbitration starts at index 0.
REQ-035 Random req/wrt_full for 10k cycles -> gnt one-hot-or-zero, never asserted while wrt_full=1, and every request granted within NUM_REQ non-full grants.

Source files
------------

// File: rtl/fifo_wrt_arbiter.sv
// Round-robin arbiter muxing NUM_REQ requesters onto one FIFO write port; grant is combinational (zero latency).
// Backpressure: wrt_full blocks every grant; optional burst lock enabled by defining WRT_ARB_LOCK_EN.
module fifo_wrt_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          wrt_clk,
    input  logic                          wrt_rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic                          wrt_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wrt_ena,
    output logic [DATA_WIDTH-1:0]         wrt_data,
    output logic [ID_W-1:0]               gnt_id
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, LOCK = 2'd2} state_t;

    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NUM_REQ);

    state_t               state_q;
    logic [ID_W-1:0]      prio_ptr_q, prio_ptr_d;
    logic [NUM_REQ-1:0]   elig;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W:0]        sum;
    logic [ID_W-1:0]      win_id;
    logic                 win_vld;
    logic                 grant_en;

`ifdef WRT_ARB_LOCK_EN
    logic [ID_W-1:0] lock_owner_q;
    logic            lock_take;

    // While locked, only the owner is visible to the round-robin search.
    always_comb begin
        elig = req;
        if (state_q == LOCK) begin
            elig = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                elig[i] = req[i] && (lock_owner_q == ID_W'(i));
            end
        end
    end

    assign lock_take = wrt_ena && req_lock[gnt_id];
`else
    logic unused_lock;

    assign elig        = req;
    assign unused_lock = ^req_lock;
`endif

    // Rotate so bit 0 is the requester at prio_ptr, then take the first set bit.
    always_comb begin
        dbl     = {elig, elig} >> prio_ptr_q;
        rot     = dbl[NUM_REQ-1:0];
        sum     = '0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && rot[i]) begin
                win_vld = 1'b1;
                sum     = {1'b0, prio_ptr_q} + (ID_W+1)'(i);
                if (sum >= NREQ_W) begin
                    sum = sum - NREQ_W;
                end
                win_id = sum[ID_W-1:0];
            end
        end
    end

    assign grant_en = wrt_rst_n && !wrt_full && win_vld;

    always_comb begin
        gnt      = '0;
        wrt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = grant_en && (win_id == ID_W'(i));
            if (gnt[i]) begin
                wrt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wrt_ena = |gnt;
    assign gnt_id  = grant_en ? win_id : '0;

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (wrt_ena) begin
            prio_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge wrt_clk) begin
        if (!wrt_rst_n) begin
            state_q    <= IDLE;
            prio_ptr_q <= '0;
`ifdef WRT_ARB_LOCK_EN
            lock_owner_q <= '0;
`endif
        end else begin
            prio_ptr_q <= prio_ptr_d;
            case (state_q)
                IDLE: begin
`ifdef WRT_ARB_LOCK_EN
                    if (lock_take) begin
                        state_q      <= LOCK;
                        lock_owner_q <= gnt_id;
                    end else
`endif
                    if (|req) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
`ifdef WRT_ARB_LOCK_EN
                    if (lock_take) begin
                        state_q      <= LOCK;
                        lock_owner_q <= gnt_id;
                    end else
`endif
                    if (req == '0) begin
                        state_q <= IDLE;
                    end
                end
`ifdef WRT_ARB_LOCK_EN
                LOCK: begin
                    // Full stalls keep the lock; owner dropping req or lock releases it.
                    if (!req[lock_owner_q]) begin
                        state_q <= ARB;
                    end else if (wrt_ena && !req_lock[lock_owner_q]) begin
                        state_q <= ARB;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wrt_arbiter.sv
// Bench for fifo_wrt_arbiter: directed scenarios with constant expectations, then random traffic
// compared cycle by cycle against an integer round-robin reference model.
module tb_fifo_wrt_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            wrt_clk = 1'b0;
    logic            wrt_rst_n;
    logic [N-1:0]    req, req_lock, gnt;
    logic [N*DW-1:0] req_data;
    logic            wrt_full, wrt_ena;
    logic [DW-1:0]   wrt_data;
    logic [IW-1:0]   gnt_id;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: next requester to search from, and lock ownership.
    int m_ptr    = 0;
    int m_owner  = 0;
    bit m_locked = 0;
    int waitc [N];

    always #5 wrt_clk = ~wrt_clk;

    fifo_wrt_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_W(IW)) dut (
        .wrt_clk  (wrt_clk),
        .wrt_rst_n(wrt_rst_n),
        .req      (req),
        .req_data (req_data),
        .req_lock (req_lock),
        .wrt_full (wrt_full),
        .gnt      (gnt),
        .wrt_ena  (wrt_ena),
        .wrt_data (wrt_data),
        .gnt_id   (gnt_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_win();
        if (!wrt_rst_n || wrt_full) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req[j] && (!m_locked || j == m_owner)) return j;
        end
        return -1;
    endfunction

    // Advance one clock, updating the model with what the edge accepts.
    task automatic tick();
        int w;
        w = model_win();
        @(posedge wrt_clk);
        if (!wrt_rst_n) begin
            m_ptr = 0; m_owner = 0; m_locked = 0;
        end else begin
            if (m_locked) begin
                if (!req[m_owner]) m_locked = 0;
                else if (w == m_owner && !req_lock[m_owner]) m_locked = 0;
            end else if (w >= 0 && req_lock[w]) begin
`ifdef WRT_ARB_LOCK_EN
                m_locked = 1; m_owner = w;
`endif
            end
            if (w >= 0) m_ptr = (w + 1) % N;
        end
        #1;
    endtask

    task automatic reset_pulse();
        wrt_rst_n = 1'b0;
        tick();
        wrt_rst_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        int w;
        logic [N-1:0]  eg;
        logic [DW-1:0] ed;
        w  = model_win();
        eg = (w < 0) ? '0 : N'(1) << w;
        ed = (w < 0) ? '0 : req_data[w*DW +: DW];
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_ena"}, 32'(wrt_ena), 32'(w >= 0));
        check({tag, "_data"}, 32'(wrt_data), 32'(ed));
        check({tag, "_id"}, 32'(gnt_id), (w < 0) ? 32'd0 : 32'(w));
    endtask

    initial begin
        logic [DW-1:0] bytes [N];
        logic [N-1:0]  alt   [2];
        logic [N-1:0]  lastg;
        int writes;

        bytes[0] = 8'hA0; bytes[1] = 8'hB1; bytes[2] = 8'hC2; bytes[3] = 8'hD3;
        alt[0] = 4'b0010; alt[1] = 4'b1000;
        req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
        req = 4'b1111; req_lock = '0; wrt_full = 1'b0; wrt_rst_n = 1'b0;

        // Reset holds outputs at zero despite all requesters active.
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ena", 32'(wrt_ena), 32'd0);
        check("rst_data", 32'(wrt_data), 32'd0);
        check("rst_id", 32'(gnt_id), 32'd0);
        tick(); tick();
        wrt_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("rr_id", 32'(gnt_id), 32'(k % N));
            check("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
            check("rr_data", 32'(wrt_data), 32'(bytes[k % N]));
            check("rr_ena", 32'(wrt_ena), 32'd1);
            tick();
        end

        // Single requester gets full throughput.
        reset_pulse();
        req = 4'b0100; writes = 0;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("solo_gnt", 32'(gnt), 32'h4);
            check("solo_id", 32'(gnt_id), 32'd2);
            writes += int'(wrt_ena);
            tick();
        end
        check("solo_writes", 32'(writes), 32'd5);

        // Full stall, then resume from unchanged pointer.
        reset_pulse();
        req = 4'b1010; wrt_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("full_gnt", 32'(gnt), 32'd0);
            check("full_ena", 32'(wrt_ena), 32'd0);
            tick();
        end
        wrt_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            check("resume_gnt", 32'(gnt), 32'(alt[k % 2]));
            tick();
        end

`ifdef WRT_ARB_LOCK_EN
        // Burst lock: three words to 0 while 1 waits, then 1.
        reset_pulse();
        req = 4'b0011; req_lock = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req_lock = 4'b0000;
            #2;
            check("lock_id", 32'(gnt_id), (k < 3) ? 32'd0 : 32'd1);
            tick();
        end
        // Reset mid-lock abandons ownership by requester 1.
        reset_pulse();
        req = 4'b0010; req_lock = 4'b0010;
        #2;
        check("lk1_id", 32'(gnt_id), 32'd1);
        tick();
        req = 4'b0011; req_lock = 4'b0000; wrt_rst_n = 1'b0;
        #2;
        check("lkrst_gnt", 32'(gnt), 32'd0);
        check("lkrst_data", 32'(wrt_data), 32'd0);
        tick();
        wrt_rst_n = 1'b1;
        #2;
        check("lkpost_id", 32'(gnt_id), 32'd0);
        check("lkpost_ena", 32'(wrt_ena), 32'd1);
        tick();
`endif

        // Random traffic against the reference model.
        reset_pulse();
        req = '0; req_lock = '0; lastg = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int w;
            for (int i = 0; i < N; i++) begin
                if (!req[i] || lastg[i]) begin
                    req[i] = ($urandom_range(0, 99) < 60);
                    req_data[i*DW +: DW] = DW'($urandom);
                end
`ifdef WRT_ARB_LOCK_EN
                req_lock[i] = ($urandom_range(0, 7) == 0);
`endif
            end
            wrt_full = ($urandom_range(0, 3) == 0);
            #2;
            check_model("rnd");
            check("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
            if (wrt_full) check("rnd_full", 32'(gnt), 32'd0);
            w = model_win();
            lastg = (w < 0) ? '0 : N'(1) << w;
`ifndef WRT_ARB_LOCK_EN
            if (w >= 0) begin
                check("rnd_fair", 32'(waitc[w] <= N - 1), 32'd1);
                for (int i = 0; i < N; i++) if (i != w && req[i]) waitc[i]++;
                waitc[w] = 0;
            end
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
